uart_comm: RTL and testbench

UART_COMM -- requirements
Module: uart_comm

---
 rtl/uart_comm.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_comm.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_comm.sv
// uart_comm: 8N1 UART command/response endpoint.
//   The receiver assembles three valid bytes into a 24-bit command, first byte
//   in the top byte. The transmitter sends one response byte per request.
//   The two directions run independently (full duplex).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   RX / TX           serial lines, idle high
//   cmd, cmd_rdy      assembled command and its pending flag
//   clr_cmd_rdy       consumer acknowledge
//   resp_data         response byte
//   send_resp         one-clock transmit request
//   resp_sent         one-clock done pulse
//   tx_busy           transmitter active
module uart_comm #(
  parameter logic [15:0] BAUD_DIV    = 16'd2604,
  parameter logic [19:0] GAP_TIMEOUT = 20'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] HALF = BAUD_DIV >> 1;
  localparam logic [15:0] LAST = BAUD_DIV - 16'd1;

  // ---------------- receiver ----------------
  logic        r_rx_meta, r_rx_sync, r_rx_prev;
  state_t      r_rx_st, w_rx_st_nxt;
  logic [15:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]  r_rx_bit, w_rx_bit_nxt;
  logic [7:0]  r_rx_shift, w_rx_shift_nxt;
  logic        w_rx_fall, w_rx_tick, w_byte_vld, w_frm_err;

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;
  assign w_rx_tick = (r_rx_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_st    <= S_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
    end else begin
      r_rx_meta  <= RX;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_st    <= w_rx_st_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  // Counter runs down; every sample happens when it reaches zero, so the start
  // sample lands mid-bit and each later sample is one bit time after it.
  always_comb begin
    w_rx_st_nxt    = r_rx_st;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    case (r_rx_st)
      S_IDLE:
        if (w_rx_fall) begin
          w_rx_st_nxt  = S_START;
          w_rx_cnt_nxt = HALF;
        end
      S_START:
        if (!w_rx_tick) w_rx_cnt_nxt = r_rx_cnt - 16'd1;
        else if (r_rx_sync) w_rx_st_nxt = S_IDLE;  // glitch, not a start bit
        else begin
          w_rx_st_nxt  = S_DATA;
          w_rx_cnt_nxt = LAST;
          w_rx_bit_nxt = 3'd0;
        end
      S_DATA:
        if (!w_rx_tick) w_rx_cnt_nxt = r_rx_cnt - 16'd1;
        else begin
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          w_rx_bit_nxt   = r_rx_bit + 3'd1;
          w_rx_cnt_nxt   = LAST;
          if (r_rx_bit == 3'd7) w_rx_st_nxt = S_STOP;
        end
      S_STOP:
        if (!w_rx_tick) w_rx_cnt_nxt = r_rx_cnt - 16'd1;
        else w_rx_st_nxt = S_IDLE;
      default: w_rx_st_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_byte_vld = (r_rx_st == S_STOP) && w_rx_tick &&  r_rx_sync;
    w_frm_err  = (r_rx_st == S_STOP) && w_rx_tick && !r_rx_sync;
  end

  // ---------------- command assembler ----------------
  logic [1:0]  r_idx;
  logic [7:0]  r_b0, r_b1;
  logic [19:0] r_gap;
  logic [23:0] r_cmd;
  logic        r_cmd_rdy;
  logic        w_gap_exp, w_cmd_done;

  assign w_gap_exp  = (r_rx_st == S_IDLE) && (r_idx != 2'd0) && (r_gap == GAP_TIMEOUT);
  assign w_cmd_done = w_byte_vld && (r_idx == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= 2'd0;
      r_b0      <= 8'd0;
      r_b1      <= 8'd0;
      r_gap     <= 20'd0;
      r_cmd     <= 24'd0;
      r_cmd_rdy <= 1'b0;
    end else begin
      // Gap timer only runs while a partial command waits for its next byte.
      if ((r_rx_st != S_IDLE) || (r_idx == 2'd0) || w_gap_exp) r_gap <= 20'd0;
      else                                                      r_gap <= r_gap + 20'd1;

      if (w_frm_err) r_idx <= 2'd0;
      else if (w_byte_vld) begin
        case (r_idx)
          2'd0:    begin r_b0 <= r_rx_shift; r_idx <= 2'd1; end
          2'd1:    begin r_b1 <= r_rx_shift; r_idx <= 2'd2; end
          default: r_idx <= 2'd0;
        endcase
      end else if (w_gap_exp) r_idx <= 2'd0;

      // A new command is taken only if the old one is gone or being acked
      // this very cycle; otherwise it is dropped and cmd holds.
      if (w_cmd_done && (!r_cmd_rdy || clr_cmd_rdy)) begin
        r_cmd     <= {r_b0, r_b1, r_rx_shift};
        r_cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
    end
  end

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;

  // ---------------- transmitter ----------------
  state_t      r_tx_st, w_tx_st_nxt;
  logic [15:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]  r_tx_bit, w_tx_bit_nxt;
  logic [7:0]  r_tx_shift, w_tx_shift_nxt;
  logic        r_tx, w_tx_line, r_resp_sent, w_resp_sent_nxt, w_tx_tick;

  assign w_tx_tick = (r_tx_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_st     <= S_IDLE;
      r_tx_cnt    <= 16'd0;
      r_tx_bit    <= 3'd0;
      r_tx_shift  <= 8'd0;
      r_tx        <= 1'b1;
      r_resp_sent <= 1'b0;
    end else begin
      r_tx_st     <= w_tx_st_nxt;
      r_tx_cnt    <= w_tx_cnt_nxt;
      r_tx_bit    <= w_tx_bit_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_tx        <= w_tx_line;
      r_resp_sent <= w_resp_sent_nxt;
    end
  end

  // Requests are accepted only in IDLE and not in the resp_sent cycle.
  always_comb begin
    w_tx_st_nxt    = r_tx_st;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    case (r_tx_st)
      S_IDLE:
        if (send_resp && !r_resp_sent) begin
          w_tx_st_nxt    = S_START;
          w_tx_shift_nxt = resp_data;
          w_tx_cnt_nxt   = LAST;
        end
      S_START:
        if (!w_tx_tick) w_tx_cnt_nxt = r_tx_cnt - 16'd1;
        else begin
          w_tx_st_nxt  = S_DATA;
          w_tx_cnt_nxt = LAST;
          w_tx_bit_nxt = 3'd0;
        end
      S_DATA:
        if (!w_tx_tick) w_tx_cnt_nxt = r_tx_cnt - 16'd1;
        else begin
          w_tx_shift_nxt = {1'b1, r_tx_shift[7:1]};
          w_tx_bit_nxt   = r_tx_bit + 3'd1;
          w_tx_cnt_nxt   = LAST;
          if (r_tx_bit == 3'd7) w_tx_st_nxt = S_STOP;
        end
      S_STOP:
        if (!w_tx_tick) w_tx_cnt_nxt = r_tx_cnt - 16'd1;
        else w_tx_st_nxt = S_IDLE;
      default: w_tx_st_nxt = S_IDLE;
    endcase
  end

  // Line level is decoded from the next state so TX leaves a flop cleanly.
  always_comb begin
    w_resp_sent_nxt = (r_tx_st == S_STOP) && w_tx_tick;
    case (w_tx_st_nxt)
      S_START: w_tx_line = 1'b0;
      S_DATA:  w_tx_line = w_tx_shift_nxt[0];
      default: w_tx_line = 1'b1;
    endcase
  end

  assign TX        = r_tx;
  assign resp_sent = r_resp_sent;
  assign tx_busy   = (r_tx_st != S_IDLE);
endmodule

// File: tb/tb_uart_comm.sv
// Directed bench for uart_comm at BAUD_DIV=8, GAP_TIMEOUT=200.
module tb_uart_comm;
  logic        clk = 1'b0, rst = 1'b1, RX = 1'b1;
  logic        TX, cmd_rdy, resp_sent, tx_busy;
  logic        clr_cmd_rdy = 1'b0, send_resp = 1'b0;
  logic [23:0] cmd;
  logic [7:0]  resp_data = 8'h00;
  int          n_tests = 0, n_fail = 0;

  uart_comm #(.BAUD_DIV(16'd8), .GAP_TIMEOUT(20'd200)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data), .send_resp(send_resp),
    .resp_sent(resp_sent), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame, driven on falling edges. clr_at_stop raises clr_cmd_rdy
  // during the cycle the receiver takes its stop-bit sample.
  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0,
                           input bit clr_at_stop = 1'b0);
    RX = 1'b0;
    idle(8);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      idle(8);
    end
    RX = !bad_stop;
    for (int i = 0; i < 8; i++) begin
      if (clr_at_stop && i == 7) clr_cmd_rdy = 1'b1;
      @(negedge clk);
    end
    clr_cmd_rdy = 1'b0;
    RX = 1'b1;
    idle(4);
  endtask

  task automatic send_cmd(input logic [23:0] c, input bit clr_last = 1'b0);
    send_byte(c[23:16]);
    send_byte(c[15:8]);
    send_byte(c[7:0], 1'b0, clr_last);
  endtask

  task automatic ack();
    clr_cmd_rdy = 1'b1;
    idle(1);
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] exp_tx;
    exp_tx = 10'b1101001010;  // A5 framed, index 0 = start bit

    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_tx", TX, 1'b1);
    chk("rst_cmd", cmd, 24'h000000);
    chk("rst_rdy", cmd_rdy, 1'b0);
    chk("rst_sent", resp_sent, 1'b0);
    chk("rst_busy", tx_busy, 1'b0);

    // basic command + acknowledge
    send_cmd(24'hA53C0F);
    chk("cmd_a5", cmd, 24'hA53C0F);
    chk("rdy_a5", cmd_rdy, 1'b1);
    ack();
    chk("clr_rdy", cmd_rdy, 1'b0);
    chk("clr_cmd", cmd, 24'hA53C0F);

    // response frame; c counts clocks since TX went low
    resp_data = 8'hA5;
    send_resp = 1'b1;
    idle(1);
    send_resp = 1'b0;
    for (int c = 0; c < 82; c++) begin
      if (c == 0) chk("tx_busy", tx_busy, 1'b1);
      if (c < 80 && (c % 8) == 4) chk($sformatf("tx_bit%0d", c / 8), TX, exp_tx[c / 8]);
      if (c == 79) chk("sent_early", resp_sent, 1'b0);
      if (c == 80) begin
        chk("sent_pulse", resp_sent, 1'b1);
        chk("busy_drop", tx_busy, 1'b0);
      end
      if (c == 81) begin
        chk("sent_once", resp_sent, 1'b0);
        chk("req_in_sent_ignored", tx_busy, 1'b0);
        chk("tx_idle", TX, 1'b1);
      end
      send_resp = (c == 40) || (c == 80);
      resp_data = (c == 40) ? 8'hFF : 8'hA5;
      @(negedge clk);
    end
    send_resp = 1'b0;

    // reset mid-frame
    resp_data = 8'h00;
    send_resp = 1'b1;
    idle(1);
    send_resp = 1'b0;
    idle(20);
    chk("mid_tx_low", TX, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mid_rst_tx", TX, 1'b1);
    chk("mid_rst_busy", tx_busy, 1'b0);
    chk("mid_rst_cmd", cmd, 24'h000000);
    idle(2);

    // inter-byte gap drops the lone first byte
    send_byte(8'h11);
    idle(250);
    send_cmd(24'h223344);
    chk("gap_cmd", cmd, 24'h223344);
    chk("gap_rdy", cmd_rdy, 1'b1);
    ack();

    // framing error on byte 2; trailing 03 then timed out
    send_byte(8'h01);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03);
    chk("ferr_rdy", cmd_rdy, 1'b0);
    idle(250);
    send_cmd(24'hDEADBE);
    chk("ferr_cmd", cmd, 24'hDEADBE);
    chk("ferr_rdy2", cmd_rdy, 1'b1);
    ack();

    // 2-clock glitch on idle line
    RX = 1'b0;
    idle(2);
    RX = 1'b1;
    idle(30);
    chk("glitch_rdy", cmd_rdy, 1'b0);
    send_cmd(24'hC35A96);
    chk("glitch_cmd", cmd, 24'hC35A96);
    ack();

    // overrun: drop while pending, accept when acked on completion
    send_cmd(24'h123456);
    chk("ovr_first", cmd, 24'h123456);
    send_cmd(24'h654321);
    chk("ovr_hold", cmd, 24'h123456);
    chk("ovr_rdy", cmd_rdy, 1'b1);
    send_cmd(24'h654321, 1'b1);
    chk("ovr_clr_cmd", cmd, 24'h654321);
    chk("ovr_clr_rdy", cmd_rdy, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
